// File: rtl/led_seq_pkg.sv
// Shared types and the lit-LED mask helper for the LED pattern sequencer.
package led_seq_pkg;

    localparam int unsigned MAX_LEDS = 16;
    localparam int unsigned MASK_W   = MAX_LEDS + 1;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2,
        MODE_BLINK  = 2'd3
    } led_mode_e;

    typedef logic [MAX_LEDS-1:0] led_vec_t;

    // Mask is computed one bit wider so fill with pos == 16 yields all-ones.
    function automatic led_vec_t led_mask(input led_mode_e m,
                                          input logic [4:0] pos,
                                          input int unsigned n);
        led_vec_t mask;
        case (m)
            MODE_CHASE,
            MODE_BOUNCE: mask = MAX_LEDS'(MASK_W'(1) << pos);
            MODE_FILL:   mask = MAX_LEDS'((MASK_W'(1) << pos) - MASK_W'(1));
            MODE_BLINK:  mask = (pos == 5'd0) ? MAX_LEDS'((MASK_W'(1) << n) - MASK_W'(1))
                                              : '0;
            default:     mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Speed-scaled step prescaler: ticks once every TICKS_PER_STEP << speed cycles.
module step_timer #(
    parameter int unsigned TICKS_PER_STEP = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int unsigned CNT_W = $clog2(TICKS_PER_STEP * 8);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit;

    // >= compare lets a shortened period fire at once instead of wrapping.
    always_comb begin
        limit = CNT_W'((TICKS_PER_STEP << speed) - 32'd1);
        tick  = !pause && (cnt_q >= limit);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (!pause) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Configurable LED pattern generator: chase, bounce, fill and blink with
// speed select, pause and optional active-low drive.
//
// mode_q      | meaning
// MODE_CHASE  | single lit LED walks up and wraps
// MODE_BOUNCE | single lit LED walks up then back down
// MODE_FILL   | LEDs fill from bit 0, then all clear
// MODE_BLINK  | all LEDs toggle on/off
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned NUM_LEDS       = 3,
    parameter int unsigned TICKS_PER_STEP = 25_000_000,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [1:0]          speed,
    input  logic                pause,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_pulse
);

    localparam int unsigned          PW       = $clog2(NUM_LEDS + 1);
    localparam logic [PW-1:0]        POS_ONE  = PW'(1);
    localparam logic [PW-1:0]        POS_LAST = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0]        POS_FILL = PW'(NUM_LEDS);
    localparam logic [NUM_LEDS-1:0]  POL      = {NUM_LEDS{ACTIVE_LOW}};
    localparam logic [NUM_LEDS-1:0]  RST_LEDS = NUM_LEDS'(1) ^ POL;

    led_mode_e           mode_q, mode_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                pulse_q, pulse_d;
    logic                mode_chg;
    logic                tick;

    assign mode_chg = (led_mode_e'(mode) != mode_q);

    step_timer #(
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_step_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (mode_chg),
        .pause (pause),
        .speed (speed),
        .tick  (tick)
    );

    function automatic logic [NUM_LEDS-1:0] drive(input led_mode_e m, input logic [PW-1:0] p);
        return NUM_LEDS'(led_mask(m, 5'(p), NUM_LEDS)) ^ POL;
    endfunction

    always_comb begin
        mode_d  = mode_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        leds_d  = leds_q;
        pulse_d = 1'b0;
        // A mode change wins over a coincident tick and never pulses.
        if (mode_chg) begin
            mode_d = led_mode_e'(mode);
            pos_d  = '0;
            dir_d  = 1'b0;
            leds_d = drive(led_mode_e'(mode), '0);
        end else if (tick) begin
            case (mode_q)
                MODE_CHASE: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
                MODE_BOUNCE: begin
                    if (NUM_LEDS == 1) begin
                        pos_d = '0;
                    end else if (!dir_q) begin
                        if (pos_q == POS_LAST) begin
                            pos_d = pos_q - POS_ONE;
                            dir_d = 1'b1;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = pos_q + POS_ONE;
                            dir_d = 1'b0;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                end
                MODE_FILL:  pos_d = (pos_q == POS_FILL) ? '0 : pos_q + POS_ONE;
                MODE_BLINK: pos_d = (pos_q == '0) ? POS_ONE : '0;
                default:    pos_d = '0;
            endcase
            leds_d  = drive(mode_q, pos_d);
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_CHASE;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            leds_q  <= RST_LEDS;
            pulse_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            leds_q  <= leds_d;
            pulse_q <= pulse_d;
        end
    end

    assign leds       = leds_q;
    assign step_pulse = pulse_q;

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator for the board's user LEDs. It supersedes the fixed three-LED, fixed-rate chaser with a configurable LED count, step period and output polarity. It also adds four run-time selectable patterns, a speed selector and a pause input. It sits directly between the board clock and the LED pins, and its mode/speed/pause inputs come from debounced switches or buttons.

## Interface
- NUM_LEDS, 3, number of LED outputs; legal range 1..16
- TICKS_PER_STEP, 25_000_000, clock cycles per pattern step at speed 0 (0.5 s at 50 MHz); must be ≥1
- ACTIVE_LOW, 0, 1 = invert every bit of `leds` at the output register

Ports (clock and reset first):
- clk  in  1  system clock; one clock domain only
- rst  in  1  reset, synchronous, active-high
- mode  in  2  pattern select: 0 chase, 1 bounce, 2 fill, 3 blink
- speed  in  2  step period = TICKS_PER_STEP << speed cycles (×1, ×2, ×4, ×8)
- pause  in  1  while high, freeze the step timer and pattern
- leds  out  NUM_LEDS  registered LED drive; bit 0 = first LED
- step_pulse  out  1  registered one-cycle pulse, high in the cycle after each pattern advance

## Operation
- State: step counter `cnt`, position `pos` (clog2(NUM_LEDS+1) bits), bounce direction `dir` (0 = up), latched mode `mode_q`.
- Reset values:
  - cnt = 0, pos = 0, dir = 0, mode_q = chase.
  - leds = 1 (LED0 lit), XOR all-ones if ACTIVE_LOW.
  - step_pulse = 0.
- Tick: asserted when `cnt ≥ (TICKS_PER_STEP << speed) − 1` and pause = 0. On a tick, cnt goes to 0. Otherwise cnt increments when pause = 0 and holds when pause = 1.
- Pattern advance on a tick:
  - Chase: pos = (pos == NUM_LEDS−1) ? 0 : pos+1. Lit LEDs = one-hot bit pos.
  - Bounce: pos moves in the direction of dir. dir flips on reaching NUM_LEDS−1 (going up) or 0 (going down).
    - Sequence for N=4: 0,1,2,3,2,1,0,1…
    - N=1: pos stays 0.
    - Lit LEDs = one-hot bit pos.
  - Fill: pos = (pos == NUM_LEDS) ? 0 : pos+1. Lit LEDs = the low pos bits, i.e. (1<<pos)−1. pos 0 = all off; the cycle is NUM_LEDS+1 steps.
  - Blink: pos toggles 0↔1. pos 0 = all lit, pos 1 = all off.
- Mode change: when `mode != mode_q`, on that edge set mode_q = mode, pos = 0, dir = 0, cnt = 0, and load leds with the pos-0 pattern of the new mode.
  - Applies even while paused.
  - Takes priority over a coincident tick.
  - Does not assert step_pulse.
- Speed change takes effect immediately. Because the compare is ≥, a shorter period never overruns: the next cycle ticks if cnt is already past the new limit.
- pause high: leds, pos, dir and cnt all hold, and step_pulse stays 0.
- rst overrides everything in the same cycle, including in mid-step and while paused.

## Timing
- leds and pos update on the same clock edge (the tick edge). step_pulse is high for exactly the one cycle following that edge.
- Steady-state step period: exactly TICKS_PER_STEP << speed cycles between step_pulse assertions.
- First advance after reset or a mode change: TICKS_PER_STEP << speed cycles after the edge that cleared cnt.
- Latency from a mode input change to new leds: 1 cycle.
- Counter width: clog2(TICKS_PER_STEP·8). No arithmetic wrap is possible.

## Structure
- Package `led_seq_pkg`:
  - mode enum: MODE_CHASE = 0, MODE_BOUNCE = 1, MODE_FILL = 2, MODE_BLINK = 3.
  - a function returning the lit-LED mask for (mode, pos, NUM_LEDS).
- Sub-module `step_timer` (params TICKS_PER_STEP; ports clk, rst, clr, pause, speed → tick). It holds the prescaler so it can be reused by other board blocks.
- Top-level holds mode_q, pos, dir, the output register and step_pulse.

## Test plan
All scenarios use NUM_LEDS = 4, TICKS_PER_STEP = 4, speed = 0 unless noted.
- Reset, mode 0: leds = 0001 after rst. Then 0010, 0100, 1000, 0001, each 4 cycles apart, with step_pulse one cycle after each change.
- Mode 1: leds sequence 0001,0010,0100,1000,0100,0010,0001,0010. Repeat with NUM_LEDS = 1: leds constantly 1 and step_pulse still every 4 cycles.
- Mode 2: leds 0000,0001,0011,0111,1111,0000. Mode 3: leds 1111,0000,1111. ACTIVE_LOW = 1 variant: every value inverted, and reset leds = 1110.
- Pause for 10 cycles mid-step: leds and step_pulse frozen, then the step completes after the remaining count.
- Mode change while paused: leds load the new pos-0 pattern on the next edge and step_pulse stays 0.
- Speed 3: step period 32 cycles. Switching speed 3→0 when cnt = 20 produces a tick on the next cycle. rst asserted mid-step restores leds = 0001 with a full 4-cycle step following.
